// File: rtl/mem_dma.sv
// mem_dma: memory bus initiator for block COPY (src->dst) and FILL
// (constant->dst). Drives a single-port memory with combinational read
// and posedge write. Every output is decoded from registered state only.
module mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  input  logic [DW-1:0] fill_val,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  state_e        state_q, state_d;
  logic          mode_q,  mode_d;
  logic          bwd_q,   bwd_d;   // COPY walks from the top byte down
  logic [AW-1:0] src_q,   src_d;
  logic [AW-1:0] dst_q,   dst_d;
  logic [DW-1:0] fill_q,  fill_d;
  logic [DW-1:0] hold_q,  hold_d;  // byte read in RD, written in WR
  logic [AW-1:0] idx_q,   idx_d;   // current offset from the base addresses
  logic [AW-1:0] cnt_q,   cnt_d;   // bytes remaining after the current one

  logic          start_bwd;

  // Next-state logic: sequencing, config latching, index stepping.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    bwd_d   = bwd_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    // Backward walk only when a COPY destination sits above its source, so
    // an overlapping move never reads a byte it has already overwritten.
    start_bwd = (mode == MODE_COPY) && (dst_addr > src_addr);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          bwd_d  = start_bwd;
          src_d  = src_addr;
          dst_d  = dst_addr;
          fill_d = fill_val;
          cnt_d  = length - AW'(1);
          idx_d  = start_bwd ? (length - AW'(1)) : '0;
          if (length == '0)            state_d = S_DONE;
          else if (mode == MODE_FILL)  state_d = S_WR;
          else                         state_d = S_RD;
        end
      end
      S_RD: begin
        hold_d  = mem_rdata;
        state_d = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - AW'(1);
          idx_d   = bwd_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
          state_d = (mode_q == MODE_FILL) ? S_WR : S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      bwd_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bwd_q   <= bwd_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from registered state; addresses wrap modulo 2**AW.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_we    = (state_q == S_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_RD: mem_addr = src_q + idx_q;
      S_WR: begin
        mem_addr  = dst_q + idx_q;
        mem_wdata = (mode_q == MODE_FILL) ? fill_q : hold_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed bench for mem_dma with a behavioural single-port
// memory (combinational read, posedge write) and hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_dma;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [7:0] length = '0;
  logic [7:0] fill_val = '0;
  logic       abort = 1'b0;
  logic       busy, done, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  logic [7:0] wr_log [$];
  int tests = 0;
  int fails = 0;

  mem_dma #(.AW(8), .DW(8)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .start     (start),
    .mode      (mode),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .fill_val  (fill_val),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory model: DUT write port has priority over bench preloads.
  always @(posedge CLK) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr]  <= tb_data;
  end

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge CLK);
    tb_we = 1'b0;
  endtask

  // Issue one transfer and watch it cycle by cycle (sampled on negedge).
  // Cycle 1 is the cycle right after the edge that sampled start.
  task automatic do_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] f, input logic ab,
                         output int done_cyc, output int we_cnt,
                         output logic [7:0] first_addr);
    done_cyc = -1; we_cnt = 0; first_addr = '0;
    wr_log.delete();
    @(negedge CLK);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_val = f;
    start = 1'b1; abort = ab;
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 1) first_addr = mem_addr;
      if (mem_we) begin
        we_cnt++;
        wr_log.push_back(mem_addr);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    int dc, wc;
    logic [7:0] fa;
    int busy_seen, done_seen;

    #1;
    check("rst_busy",  busy,      0);
    check("rst_done",  done,      0);
    check("rst_we",    mem_we,    0);
    check("rst_addr",  mem_addr,  0);
    check("rst_wdata", mem_wdata, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // 1: FILL 0x10..0x13 with A5, neighbour untouched.
    poke(8'h14, 8'hEE);
    do_xfer(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 1'b0, dc, wc, fa);
    check("fill_done_cyc", dc, 5);
    check("fill_we_cnt",   wc, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_order%0d", i), (i < wr_log.size()) ? wr_log[i] : 8'hXX, 8'h10 + i);
      check($sformatf("fill_m%0d", i), mem[8'h10 + i], 8'hA5);
    end
    check("fill_m14", mem[8'h14], 8'hEE);

    // 2: COPY 3 bytes 0x00 -> 0x40.
    poke(8'h00, 8'h01); poke(8'h01, 8'h02); poke(8'h02, 8'h03);
    do_xfer(1'b0, 8'h00, 8'h40, 8'd3, 8'h00, 1'b0, dc, wc, fa);
    check("copy_done_cyc", dc, 7);
    check("copy_we_cnt",   wc, 3);
    check("copy_m40", mem[8'h40], 8'h01);
    check("copy_m41", mem[8'h41], 8'h02);
    check("copy_m42", mem[8'h42], 8'h03);

    // 3: overlapping COPY 0x20 -> 0x21 must walk backward.
    poke(8'h20, 8'h11); poke(8'h21, 8'h22); poke(8'h22, 8'h33); poke(8'h23, 8'h44);
    do_xfer(1'b0, 8'h20, 8'h21, 8'd4, 8'h00, 1'b0, dc, wc, fa);
    check("ovl_first_rd", fa, 8'h23);
    check("ovl_done_cyc", dc, 9);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovl_order%0d", i), (i < wr_log.size()) ? wr_log[i] : 8'hXX, 8'h24 - i);
    check("ovl_m21", mem[8'h21], 8'h11);
    check("ovl_m22", mem[8'h22], 8'h22);
    check("ovl_m23", mem[8'h23], 8'h33);
    check("ovl_m24", mem[8'h24], 8'h44);

    // 4: FILL wrapping past 0xFF, then a zero-length request.
    do_xfer(1'b1, 8'h00, 8'hFE, 8'd3, 8'h5C, 1'b0, dc, wc, fa);
    check("wrap_we_cnt", wc, 3);
    check("wrap_a0", (wr_log.size() > 0) ? wr_log[0] : 8'hXX, 8'hFE);
    check("wrap_a1", (wr_log.size() > 1) ? wr_log[1] : 8'hXX, 8'hFF);
    check("wrap_a2", (wr_log.size() > 2) ? wr_log[2] : 8'hXX, 8'h00);
    check("wrap_m00", mem[8'h00], 8'h5C);
    check("wrap_mff", mem[8'hFF], 8'h5C);
    do_xfer(1'b0, 8'h30, 8'h50, 8'd0, 8'h00, 1'b0, dc, wc, fa);
    check("zero_done_cyc", dc, 1);
    check("zero_we_cnt",   wc, 0);

    // start together with abort in IDLE: abort ignored.
    poke(8'hB0, 8'h00);
    do_xfer(1'b1, 8'h00, 8'hB0, 8'd1, 8'h6D, 1'b1, dc, wc, fa);
    check("stab_done_cyc", dc, 2);
    check("stab_mb0", mem[8'hB0], 8'h6D);

    // 5: COPY 8 forward, abort during 2nd WR, start while busy ignored.
    for (int i = 0; i < 8; i++) poke(8'h70 + i, 8'hC0 + i);
    poke(8'h62, 8'h99);
    poke(8'h90, 8'h00);
    @(negedge CLK);
    mode = 1'b0; src_addr = 8'h70; dst_addr = 8'h60; length = 8'd8; start = 1'b1;
    @(negedge CLK);                       // cycle 1: RD
    start = 1'b0;
    @(negedge CLK);                       // cycle 2: WR
    mode = 1'b1; dst_addr = 8'h90; length = 8'd1; fill_val = 8'h5A; start = 1'b1;
    @(negedge CLK);                       // cycle 3: RD
    start = 1'b0;
    check("abt_c3_busy", busy, 1);
    check("abt_c3_we",   mem_we, 0);
    @(negedge CLK);                       // cycle 4: second WR
    check("abt_c4_we",   mem_we, 1);
    check("abt_c4_addr", mem_addr, 8'h61);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("abt_busy_after", busy, 0);
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      if (busy) busy_seen++;
      @(negedge CLK);
    end
    check("abt_no_done", done_seen, 0);
    check("abt_stay_idle", busy_seen, 0);
    check("abt_m60", mem[8'h60], 8'hC0);
    check("abt_m61", mem[8'h61], 8'hC1);
    check("abt_m62", mem[8'h62], 8'h99);
    check("abt_m90", mem[8'h90], 8'h00);

    // 6: reset in the middle of a 10-byte FILL after 3 writes.
    poke(8'hA3, 8'h3C);
    @(negedge CLK);
    mode = 1'b1; dst_addr = 8'hA0; length = 8'd10; fill_val = 8'h77; start = 1'b1;
    @(negedge CLK);                       // cycle 1
    start = 1'b0;
    repeat (3) @(negedge CLK);            // cycle 4: 4th write pending
    check("rmid_we_pre", mem_we, 1);
    #1 RESET_N = 1'b0;
    #1;
    check("rmid_we",    mem_we,    0);
    check("rmid_busy",  busy,      0);
    check("rmid_done",  done,      0);
    check("rmid_addr",  mem_addr,  0);
    check("rmid_wdata", mem_wdata, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    check("rmid_ma0", mem[8'hA0], 8'h77);
    check("rmid_ma2", mem[8'hA2], 8'h77);
    check("rmid_ma3", mem[8'hA3], 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
